sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 26, is the request address width in 32-bit words.
REQ-002 Parameter DATA_W, default 32, is the data width.
REQ-003 Parameter DEPTH_LOG2, default 16, is the log2 of the implemented storage words.
REQ-004 Parameter READ_LAT, default 2, legal range 1..4, is the cycles from read acceptance to R0_dvalid.
REQ-005 Parameter STALL_EN, default 0; when 1, pseudo-random wait states are injected.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, is the stall LFSR reset value and SHALL be nonzero.
REQ-007 The block has one clock; reset is synchronous and active-high.
REQ-008 Port clk is an input of 1 bit and is the sole clock, with all state updated on its rising edge.
REQ-009 Port rst is an input of 1 bit and is the synchronous active-high reset.
REQ-010 Port W0_addr is an input of ADDR_W bits and carries the write word address.
REQ-011 Port W0_valid is an input of 1 bit and signals a write request.
REQ-012 Port W0_ready is an output of 1 bit and signals write acceptance.
REQ-013 Port W0_data is an input of DATA_W bits and carries the write data.
REQ-014 Port R0_addr is an input of ADDR_W bits and carries the read word address.
REQ-015 Port R0_valid is an input of 1 bit and signals a read request.
REQ-016 Port R0_ready is an output of 1 bit and signals read acceptance.
REQ-017 Port R0_data is an output of DATA_W bits and carries read data, held until the next return.
REQ-018 Port R0_dvalid is an output of 1 bit and is a one-cycle strobe marking new R0_data.
REQ-019 Ports stat_wr_cnt and stat_rd_cnt are outputs of 32 bits each and count accepted writes and reads.
REQ-020 Port stat_conflict_cnt is an output of 32 bits and counts cycles in which both W0_valid and R0_valid are high.

Function
REQ-021 Storage SHALL be a single-port array of 2^DEPTH_LOG2 words, performing at most one access per cycle.
REQ-022 The array SHALL be indexed by addr[DEPTH_LOG2-1:0]; upper address bits SHALL be ignored, so addresses alias by wrap-around.
REQ-023 W0_ready and R0_ready SHALL be combinational from valid, grant and stall, and SHALL never both be high in the same cycle.
REQ-024 A transfer SHALL occur on any cycle where valid && ready is high; writes SHALL commit to the array on that edge.
REQ-025 Arbitration with one valid high: that side is granted.
REQ-026 Arbitration with both valid high: round-robin, granting the side not granted last; the last-grant register SHALL update only on an actual transfer.
REQ-027 The last-grant register SHALL reset to "write", so the first conflict grants the read.
REQ-028 The stall logic SHALL use a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle.
REQ-029 With STALL_EN=1, both readies SHALL be forced low when lfsr[1:0]==2'b00; with STALL_EN=0, stall SHALL be constant 0.
REQ-030 The read pipeline SHALL be READ_LAT stages of valid and address or data, and R0_dvalid SHALL pulse exactly READ_LAT cycles after the accepting edge.
REQ-031 Reads SHALL return data in acceptance order, sustaining one read per cycle.
REQ-032 A read accepted in the cycle after a write to the same index SHALL return the newly written data, which follows from single-port serialization.
REQ-033 Requesters may change addr or data while ready is low; no request is latched before acceptance.
REQ-034 stat counters SHALL saturate at 32'hFFFF_FFFF rather than wrap.

Reset
REQ-035 On rst: W0_ready=0, R0_ready=0, R0_dvalid=0, R0_data=0, all stat counters=0, pipeline valids cleared, last-grant="write", and LFSR=LFSR_SEED.
REQ-036 Array contents SHALL NOT be cleared by rst.
REQ-037 Reads in flight during a mid-operation reset SHALL be discarded with no R0_dvalid.
REQ-038 The readies SHALL stay low during the cycle rst is high.

Structure
REQ-039 A shared package SHALL hold the LFSR tap constant, the grant encoding (GNT_W, GNT_R) and the saturating-increment function.
REQ-040 One sub-module, sram_resp_lfsr, SHALL implement the stall generator.
REQ-041 The array SHALL be a plain inferred memory, allowing later swap to a macro.

Verification
REQ-042 Write 0x12345678 to addr 0x10, then read addr 0x10 -> R0_dvalid exactly 2 cycles after the read accept with R0_data=0x12345678, stat_wr_cnt=1 and stat_rd_cnt=1.
REQ-043 Hold W0_valid and R0_valid high for 6 cycles -> grants alternate R,W,R,W,R,W, stat_conflict_cnt=6 and the readies are never both high.
REQ-044 Write addr 0x0000005 then read addr 0x2000005 with DEPTH_LOG2=16 -> the read returns the written data (alias).
REQ-045 Issue 8 back-to-back reads of addresses 0..7 preloaded with i*3 -> 8 consecutive R0_dvalid pulses with data 0,3,...,21 in order.
REQ-046 Assert rst one cycle after a read is accepted -> no R0_dvalid, R0_data=0 and counters=0, and array data is still readable after reset.
REQ-047 With STALL_EN=1, send a 1000-request random mix checked against a reference model -> no data mismatch and ready low exactly on LFSR-stall cycles.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared constants and helpers for the SRAM responder: stall LFSR taps,
// grant encoding and the saturating statistics increment.
package sram_responder_pkg;

  // x^16 + x^14 + x^13 + x^11, as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    GNT_W = 1'b0,
    GNT_R = 1'b1
  } gnt_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/sram_resp_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that raises a wait-state request
// whenever its two low bits are both zero.
module sram_resp_lfsr
  import sram_responder_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          STALL_EN = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic stall_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall_o = (STALL_EN != 0) && (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/sram_responder.sv
// Single-port SRAM model with a round-robin write/read arbiter, a fixed
// latency read return pipeline, optional random wait states and statistics.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int          ADDR_W     = 26,
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          READ_LAT   = 2,
  parameter int          STALL_EN   = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_valid,
  output logic              W0_ready,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_valid,
  output logic              R0_ready,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_dvalid,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_conflict_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  stall;
  gnt_e                  gnt, last_q, last_d;
  logic                  wr_xfer, rd_xfer;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [READ_LAT-1:0]   vld_q;
  logic [DATA_W-1:0]     dat_q [READ_LAT];
  logic [31:0]           stat_wr_q, stat_rd_q, stat_cf_q;

  sram_resp_lfsr #(
    .SEED     (LFSR_SEED),
    .STALL_EN (STALL_EN)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_i   (rst),
    .stall_o (stall)
  );

  // On a conflict the side that did not win the last transfer goes next.
  always_comb begin
    gnt = GNT_W;
    if (W0_valid && R0_valid) gnt = (last_q == GNT_W) ? GNT_R : GNT_W;
    else if (R0_valid)        gnt = GNT_R;
    W0_ready = !rst && !stall && W0_valid && (gnt == GNT_W);
    R0_ready = !rst && !stall && R0_valid && (gnt == GNT_R);
    wr_xfer  = W0_valid && W0_ready;
    rd_xfer  = R0_valid && R0_ready;
    idx      = (gnt == GNT_W) ? W0_addr[DEPTH_LOG2-1:0] : R0_addr[DEPTH_LOG2-1:0];
  end

  always_comb begin
    last_d = last_q;
    if (wr_xfer)      last_d = GNT_W;
    else if (rd_xfer) last_d = GNT_R;
  end

  if (ADDR_W > DEPTH_LOG2) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^{W0_addr[ADDR_W-1:DEPTH_LOG2], R0_addr[ADDR_W-1:DEPTH_LOG2]};
  end

  // Storage is left out of reset so it can become a macro later.
  always_ff @(posedge clk) begin
    if (wr_xfer) mem[idx] <= W0_data;
  end

  // Each data stage loads only behind a valid, so the last one holds R0_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_xfer;
      if (rd_xfer) dat_q[0] <= mem[idx];
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= GNT_W;
      stat_wr_q <= '0;
      stat_rd_q <= '0;
      stat_cf_q <= '0;
    end else begin
      last_q    <= last_d;
      stat_wr_q <= sat_inc(stat_wr_q, wr_xfer);
      stat_rd_q <= sat_inc(stat_rd_q, rd_xfer);
      stat_cf_q <= sat_inc(stat_cf_q, W0_valid && R0_valid);
    end
  end

  assign R0_dvalid         = vld_q[READ_LAT-1];
  assign R0_data           = dat_q[READ_LAT-1];
  assign stat_wr_cnt       = stat_wr_q;
  assign stat_rd_cnt       = stat_rd_q;
  assign stat_conflict_cnt = stat_cf_q;

endmodule
